matrix_multiplier: RTL and testbench
====================================

// Module: matrix_multiplier
// PURPOSE
//  Consumes the 32x32 byte matrices held by the matrix loader and produces C = A x B.
//  - Waits for the loader's complete flag.
//  - Fetches A rows and B columns through the loader's requested_a_row / requested_b_col lookup.
//  - Computes each C element as a multi-cycle MAC.
//  - Streams results (row, col, value) downstream on a valid/ready handshake, row-major.
// PARAMETERS
//  N       32  matrix dimension; row/col buses are N*W bits
//  W       8   element width, unsigned
//  LANES   4   MACs per cycle; must divide N; dot product takes N/LANES cycles
//  RD_LAT  1   cycles from request index change to valid a_row_in/b_col_in
//  CW      21  result width = 2*W + $clog2(N); 32*255*255 = 2080800 fits
// PORTS
//  inter_refclk     in   1       single clock, shared with loader read side
//  rst_n            in   1       synchronous, active-low reset
//  start            in   1       loader complete flag, level
//  a_row_in         in   N*W     loader a_row_out; element k = bits [W*k+W-1 : W*k]
//  b_col_in         in   N*W     loader b_col_out; same packing
//  requested_a_row  out  $clog2(N)  A row index to loader
//  requested_b_col  out  $clog2(N)  B column index to loader
//  c_valid          out  1       result valid
//  c_ready          in   1       downstream accepts when c_valid & c_ready
//  c_row            out  $clog2(N)  row of current result
//  c_col            out  $clog2(N)  column of current result
//  c_data           out  CW      result value, unsigned
//  busy             out  1       high in every state except IDLE and DONE
//  done             out  1       high in DONE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; all outputs and indices, accumulator, counters = 0.
//  - Reset mid-operation aborts the multiply. No partial result is presented after reset.
//  - IDLE: start=1 -> REQ with i=0, j=0.
//  - REQ (1 cycle): register requested_a_row=i, requested_b_col=j -> WAIT; load wait counter RD_LAT.
//  - WAIT: count down RD_LAT cycles; on the last cycle latch a_row_in/b_col_in into local regs -> MAC.
//    Local copies are held; loader buses may change afterwards.
//  - MAC: each cycle acc += sum of LANES products of elements k..k+LANES-1, k stepping by LANES.
//    First MAC cycle clears acc (acc = partial sum).
//    After N/LANES cycles -> OUT.
//  - OUT: c_valid=1; c_row=i, c_col=j, c_data=acc are stable while c_valid & !c_ready.
//  - OUT on handshake:
//    - j<N-1: j++ -> REQ.
//    - j=N-1, i<N-1: j=0, i++ -> REQ.
//    - i=j=N-1: -> DONE.
//    c_valid drops the cycle after the handshake.
//  - DONE: done=1. Stays until start=0, then -> IDLE. A held start never triggers a second run.
//  - start falling during busy is ignored; the run completes.
//  - Arithmetic is unsigned, full width, no saturation. Products are 2W bits; the lane sum and acc are CW bits.
//  - Per-element latency with no stall: 1 + RD_LAT + N/LANES + 1 cycles (default 11).
//  - Total with c_ready=1: N*N*11 = 11264 cycles from start to done.
// TESTING
//  1. Loader model all bytes 0xFF, c_ready=1
//     -> 1024 results, every c_data=2080800; row-major order; done after 11264 cycles.
//  2. A = identity (diag 0x01, else 0), B[r][c] = (r+c)&0xFF
//     -> c_data = (i+j)&0xFF for every (i,j).
//  3. A diag 0x00, off-diag 0xFF; B = all 0x01
//     -> every c_data = 31*255 = 7905.
//  4. Backpressure: c_ready low 5 cycles at result (3,7)
//     -> c_valid, c_row=3, c_col=7, c_data stable; no index advance; no loss or duplicate.
//  5. rst_n low 1 cycle during MAC of (10,4)
//     -> next cycle all outputs 0, state IDLE; start still 1 -> fresh run from (0,0).
//  6. start held high past done
//     -> done stays 1, no new requests.
//     Drop start -> IDLE, done=0; reassert -> new run.
//     Repeat test 1 with LANES=1 and LANES=32: same results, latency N+2+RD_LAT and 3+RD_LAT.

Source files
------------

// File: rtl/matrix_multiplier.sv
// rtl/matrix_multiplier.sv - C = A x B over the loader's row/column lookup, streamed out row-major
//
// Purpose:
//   Waits for the loader complete flag, then for every (i,j) requests A row i and
//   B column j, keeps a local copy, runs an N/LANES-cycle multiply-accumulate and
//   presents (row, col, value) on a valid/ready handshake.
//
// Ports:
//   inter_refclk     clock shared with the loader read side
//   rst_n            synchronous active-low reset
//   start            loader complete flag (level)
//   a_row_in         loader A row, element k at bits [W*k +: W]
//   b_col_in         loader B column, same packing
//   requested_a_row  A row index presented to the loader
//   requested_b_col  B column index presented to the loader
//   c_valid/c_ready  result handshake
//   c_row/c_col      coordinates of the presented result
//   c_data           result value, unsigned CW bits
//   busy             high in every state except IDLE and DONE
//   done             high in DONE
module matrix_multiplier #(
   parameter int N      = 32,
   parameter int W      = 8,
   parameter int LANES  = 4,
   parameter int RD_LAT = 1,
   parameter int CW     = 2*W + $clog2(N)
) (
   input  logic                  inter_refclk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [N*W-1:0]        a_row_in,
   input  logic [N*W-1:0]        b_col_in,
   output logic [$clog2(N)-1:0]  requested_a_row,
   output logic [$clog2(N)-1:0]  requested_b_col,
   output logic                  c_valid,
   input  logic                  c_ready,
   output logic [$clog2(N)-1:0]  c_row,
   output logic [$clog2(N)-1:0]  c_col,
   output logic [CW-1:0]         c_data,
   output logic                  busy,
   output logic                  done
);

   localparam int IW    = $clog2(N);
   localparam int BEATS = N / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = $clog2(RD_LAT + 1);
   localparam int PW    = 2 * W;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_MAC, S_OUT, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    i_q, i_d, j_q, j_d;
   logic [IW-1:0]    req_a_q, req_a_d, req_b_q, req_b_d;
   logic [LW-1:0]    lat_q, lat_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic [N*W-1:0]   a_q, a_d, b_q, b_d;

   logic [W-1:0]     a_el [N];
   logic [W-1:0]     b_el [N];
   logic [CW-1:0]    lane_sum;
   int               idx;

   // Element views of the held local copies.
   for (genvar g = 0; g < N; g++) begin : g_el
      assign a_el[g] = a_q[g*W +: W];
      assign b_el[g] = b_q[g*W +: W];
   end

   // Sum of the LANES products covering elements beat*LANES .. beat*LANES+LANES-1.
   always_comb begin
      lane_sum = '0;
      idx      = 0;
      for (int l = 0; l < LANES; l++) begin
         idx      = int'(beat_q) * LANES + l;
         lane_sum = lane_sum + CW'(PW'(a_el[idx[IW-1:0]]) * PW'(b_el[idx[IW-1:0]]));
      end
   end

   always_ff @(posedge inter_refclk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         req_a_q <= '0;
         req_b_q <= '0;
         lat_q   <= '0;
         beat_q  <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         req_a_q <= req_a_d;
         req_b_q <= req_b_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      req_a_d = req_a_q;
      req_b_d = req_b_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            req_a_d = i_q;
            req_b_d = j_q;
            lat_d   = LW'(RD_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Latch on the last wait cycle; the loader may change its buses afterwards.
            if (lat_q <= LW'(1)) begin
               a_d     = a_row_in;
               b_d     = b_col_in;
               beat_d  = '0;
               state_d = S_MAC;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         S_MAC: begin
            // First beat overwrites whatever the previous element left in acc.
            acc_d = (beat_q == '0) ? lane_sum : acc_q + lane_sum;
            if (beat_q == BW'(BEATS - 1)) begin
               beat_d  = '0;
               state_d = S_OUT;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         S_OUT: begin
            if (c_ready) begin
               if (j_q != IW'(N - 1)) begin
                  j_d     = j_q + IW'(1);
                  state_d = S_REQ;
               end else if (i_q != IW'(N - 1)) begin
                  j_d     = '0;
                  i_d     = i_q + IW'(1);
                  state_d = S_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // A held start must not retrigger; wait for it to drop.
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      c_valid         = (state_q == S_OUT);
      busy            = (state_q != S_IDLE) && (state_q != S_DONE);
      done            = (state_q == S_DONE);
      requested_a_row = req_a_q;
      requested_b_col = req_b_q;
      c_row           = i_q;
      c_col           = j_q;
      c_data          = acc_q;
   end

endmodule

// File: tb/tb_matrix_multiplier.sv
// tb/tb_matrix_multiplier.sv - scoreboard bench for matrix_multiplier
module tb_matrix_multiplier;

   localparam int N  = 32;
   localparam int W  = 8;
   localparam int IW = 5;
   localparam int CW = 21;
   localparam int RW = 2*IW + CW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, aux_rst_n, start, aux_start, c_ready;
   logic [N*W-1:0]    a_row_in, b_col_in;
   logic [N*W-1:0]    all_ff = '1;
   logic [IW-1:0]     requested_a_row, requested_b_col, c_row, c_col;
   logic [CW-1:0]     c_data;
   logic              c_valid, busy, done;

   logic [IW-1:0]     l1_ra, l1_rb, l1_row, l1_col, l32_ra, l32_rb, l32_row, l32_col;
   logic [CW-1:0]     l1_data, l32_data;
   logic              l1_valid, l1_busy, l1_done, l32_valid, l32_busy, l32_done;

   matrix_multiplier #(.N(N), .W(W), .LANES(4), .RD_LAT(1), .CW(CW)) dut (
      .inter_refclk(clk), .rst_n(rst_n), .start(start),
      .a_row_in(a_row_in), .b_col_in(b_col_in),
      .requested_a_row(requested_a_row), .requested_b_col(requested_b_col),
      .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_col(c_col),
      .c_data(c_data), .busy(busy), .done(done));

   matrix_multiplier #(.N(N), .W(W), .LANES(1), .RD_LAT(1), .CW(CW)) u_l1 (
      .inter_refclk(clk), .rst_n(aux_rst_n), .start(aux_start),
      .a_row_in(all_ff), .b_col_in(all_ff),
      .requested_a_row(l1_ra), .requested_b_col(l1_rb),
      .c_valid(l1_valid), .c_ready(1'b1), .c_row(l1_row), .c_col(l1_col),
      .c_data(l1_data), .busy(l1_busy), .done(l1_done));

   matrix_multiplier #(.N(N), .W(W), .LANES(32), .RD_LAT(1), .CW(CW)) u_l32 (
      .inter_refclk(clk), .rst_n(aux_rst_n), .start(aux_start),
      .a_row_in(all_ff), .b_col_in(all_ff),
      .requested_a_row(l32_ra), .requested_b_col(l32_rb),
      .c_valid(l32_valid), .c_ready(1'b1), .c_row(l32_row), .c_col(l32_col),
      .c_data(l32_data), .busy(l32_busy), .done(l32_done));

   logic [7:0]    ma [N][N];
   logic [7:0]    mb [N][N];
   logic [RW-1:0] sb [$];
   int            total = 0, bad = 0, cyc = 0;
   int            l1_cnt = 0, l32_cnt = 0, l1_done_cyc = -1, l32_done_cyc = -1, aux_s = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Loader model: answers the current request indices within one cycle.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         a_row_in[k*W +: W] = ma[requested_a_row][k];
         b_col_in[k*W +: W] = mb[k][requested_b_col];
      end
   end

   task automatic push_expected();
      int sum;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int k = 0; k < N; k++) sum += int'(ma[i][k]) * int'(mb[k][j]);
            sb.push_back({IW'(i), IW'(j), CW'(sum)});
         end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && c_valid === 1'b1 && c_ready === 1'b1) begin
         if (sb.size() == 0) chk("extra_result", 64'(c_valid), 64'd0);
         else chk("result", 64'({c_row, c_col, c_data}), 64'(sb.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (aux_rst_n === 1'b1 && l1_valid === 1'b1) begin
         if (l1_cnt >= N*N) chk("l1_extra", 64'(l1_valid), 64'd0);
         else chk("l1_result", 64'({l1_row, l1_col, l1_data}),
                  64'({IW'(l1_cnt / N), IW'(l1_cnt % N), CW'(2080800)}));
         l1_cnt++;
      end
      if (aux_rst_n === 1'b1 && l32_valid === 1'b1) begin
         if (l32_cnt >= N*N) chk("l32_extra", 64'(l32_valid), 64'd0);
         else chk("l32_result", 64'({l32_row, l32_col, l32_data}),
                  64'({IW'(l32_cnt / N), IW'(l32_cnt % N), CW'(2080800)}));
         l32_cnt++;
      end
      if (l1_done === 1'b1 && l1_done_cyc < 0) l1_done_cyc = cyc;
      if (l32_done === 1'b1 && l32_done_cyc < 0) l32_done_cyc = cyc;
   end

   // Counts edges from the first edge that sees start until done rises.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      @(posedge clk);
      while (n < budget) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      chk("done_reached", 64'(done), 64'd1);
   endtask

   task automatic wait_req(input int r, input int c, input string tag);
      int n = 0;
      while (!(requested_a_row == IW'(r) && requested_b_col == IW'(c)) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 64'({requested_a_row, requested_b_col}), 64'({IW'(r), IW'(c)}));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; aux_rst_n = 1'b0; start = 1'b0; aux_start = 1'b0; c_ready = 1'b1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin ma[r][c] = 8'hFF; mb[r][c] = 8'hFF; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(c_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_req", 64'({requested_a_row, requested_b_col}), 64'd0);
      chk("rst_result", 64'({c_row, c_col, c_data}), 64'd0);
      chk("rst_aux", 64'({l1_valid, l1_busy, l1_done, l32_valid, l32_busy, l32_done}), 64'd0);
      rst_n = 1'b1; aux_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All 0xFF; the two lane-count variants run alongside on the same data.
      push_expected();
      start = 1'b1; aux_start = 1'b1; aux_s = cyc;
      wait_done(12000, n);
      chk("t1_latency", 64'(n), 64'd11264);
      chk("t1_drained", 64'(sb.size()), 64'd0);

      // Held start past done.
      repeat (40) @(posedge clk);
      #1;
      chk("t6_done_held", 64'(done), 64'd1);
      chk("t6_busy_held", 64'(busy), 64'd0);
      chk("t6_no_new_req", 64'({requested_a_row, requested_b_col}), 64'({IW'(31), IW'(31)}));
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_idle_done", 64'(done), 64'd0);
      chk("t6_idle_busy", 64'(busy), 64'd0);

      // Identity x (r+c), with backpressure on (3,7).
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? 8'h01 : 8'h00;
            mb[r][c] = 8'(r + c);
         end
      push_expected();
      start = 1'b1;
      wait_req(3, 7, "t4_reach");
      c_ready = 1'b0;
      n = 0;
      while (!c_valid && n < 20) begin @(posedge clk); #1; n++; end
      for (int s = 0; s < 5; s++) begin
         chk("t4_stall_out", 64'({c_valid, c_row, c_col, c_data}),
             64'({1'b1, IW'(3), IW'(7), CW'(10)}));
         chk("t4_stall_req", 64'({requested_a_row, requested_b_col}), 64'({IW'(3), IW'(7)}));
         @(posedge clk);
         #1;
      end
      c_ready = 1'b1;
      wait_done(12000, n);
      chk("t2_drained", 64'(sb.size()), 64'd0);
      start = 1'b0;
      @(posedge clk);
      #1;

      // Diag 0 / off-diag 0xFF times all ones, with a reset inside (10,4).
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? 8'h00 : 8'hFF;
            mb[r][c] = 8'h01;
         end
      push_expected();
      start = 1'b1;
      wait_req(10, 4, "t5_reach");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_rst_flags", 64'({c_valid, busy, done}), 64'd0);
      chk("t5_rst_req", 64'({requested_a_row, requested_b_col}), 64'd0);
      chk("t5_rst_result", 64'({c_row, c_col, c_data}), 64'd0);
      rst_n = 1'b1;
      sb.delete();
      push_expected();
      wait_done(12000, n);
      chk("t5_rerun_latency", 64'(n), 64'd11264);
      chk("t3_drained", 64'(sb.size()), 64'd0);
      start = 1'b0;

      n = 0;
      while ((l1_done_cyc < 0 || l32_done_cyc < 0) && n < 5000) begin @(posedge clk); #1; n++; end
      chk("l1_count", 64'(l1_cnt), 64'd1024);
      chk("l32_count", 64'(l32_cnt), 64'd1024);
      chk("l1_latency", 64'(l1_done_cyc - aux_s - 1), 64'(35 * 1024));
      chk("l32_latency", 64'(l32_done_cyc - aux_s - 1), 64'(4 * 1024));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
